// File: rtl/aes_sbox_sched.sv
// Shares one pipelined masked AES S-box between the state path (16 bytes) and
// the key schedule (4 bytes); one share-byte issued per cycle when randomness is fresh.
module aes_sbox_sched #(
    parameter int SHARES       = 2,
    parameter int SBOX_LATENCY = 4
) (
    input  logic                    ClkxCI,
    input  logic                    RstxBI,
    input  logic                    StateStartxSI,
    input  logic [128*SHARES-1:0]   StatexDI,
    input  logic                    KeyStartxSI,
    input  logic [32*SHARES-1:0]    KeyWordxDI,
    input  logic                    RndValidxSI,
    output logic                    RndTakexSO,
    output logic [8*SHARES-1:0]     SboxInxDO,
    input  logic [8*SHARES-1:0]     SboxOutxDI,
    output logic [128*SHARES-1:0]   StateResultxDO,
    output logic                    StateDonexSO,
    output logic [32*SHARES-1:0]    KeyResultxDO,
    output logic                    KeyDonexSO,
    output logic                    BusyxSO
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t                          fsmxDP;
    logic                            jobKeyxDP;
    logic                            statePendxDP, keyPendxDP;
    logic [SHARES-1:0][15:0][7:0]    stateLatxDP, workxDP, stateResxDP;
    logic [SHARES-1:0][3:0][7:0]     keyLatxDP, keyResxDP;
    logic [4:0]                      idxxDP, numxDP, capCntxDP;
    logic [SBOX_LATENCY-1:0]         vldPipexDP, tagPipexDP;
    logic                            stateDonexDP, keyDonexDP;

    logic                            issuexS, capturexS, capTagxS, lastCapxS;
    logic                            stateActivexS, keyActivexS;
    logic [SHARES-1:0][7:0]          issueBytexD, sboxOutxD;
    logic [SHARES-1:0][15:0][7:0]    workNextxD;

    assign issuexS       = (fsmxDP == ISSUE) && RndValidxSI;
    assign capturexS     = vldPipexDP[SBOX_LATENCY-1];
    assign capTagxS      = tagPipexDP[SBOX_LATENCY-1];
    assign lastCapxS     = capturexS && (capCntxDP == numxDP - 5'd1);
    assign stateActivexS = (fsmxDP != IDLE) && !jobKeyxDP;
    assign keyActivexS   = (fsmxDP != IDLE) && jobKeyxDP;
    assign sboxOutxD     = SboxOutxDI;

    // Share s of the issued byte comes only from share s of the latched job data.
    always_comb begin
        issueBytexD = '0;
        for (int s = 0; s < SHARES; s++) begin
            issueBytexD[s] = jobKeyxDP ? keyLatxDP[s][idxxDP[1:0]] : stateLatxDP[s][idxxDP[3:0]];
        end
    end

    always_comb begin
        workNextxD = workxDP;
        if (capturexS) begin
            for (int s = 0; s < SHARES; s++) begin
                workNextxD[s][capCntxDP[3:0]] = sboxOutxD[s];
            end
        end
    end

    assign SboxInxDO      = issuexS ? issueBytexD : '0;
    assign RndTakexSO     = issuexS;
    assign StateResultxDO = stateResxDP;
    assign KeyResultxDO   = keyResxDP;
    assign StateDonexSO   = stateDonexDP;
    assign KeyDonexSO     = keyDonexDP;
    assign BusyxSO        = (fsmxDP != IDLE) | statePendxDP | keyPendxDP;

    always_ff @(posedge ClkxCI or negedge RstxBI) begin
        if (!RstxBI) begin
            fsmxDP       <= IDLE;
            jobKeyxDP    <= 1'b0;
            statePendxDP <= 1'b0;
            keyPendxDP   <= 1'b0;
            stateLatxDP  <= '0;
            keyLatxDP    <= '0;
            workxDP      <= '0;
            stateResxDP  <= '0;
            keyResxDP    <= '0;
            idxxDP       <= '0;
            numxDP       <= '0;
            capCntxDP    <= '0;
            vldPipexDP   <= '0;
            tagPipexDP   <= '0;
            stateDonexDP <= 1'b0;
            keyDonexDP   <= 1'b0;
        end else begin
            stateDonexDP <= 1'b0;
            keyDonexDP   <= 1'b0;

            if (StateStartxSI && !statePendxDP && !stateActivexS) begin
                statePendxDP <= 1'b1;
                stateLatxDP  <= StatexDI;
            end
            if (KeyStartxSI && !keyPendxDP && !keyActivexS) begin
                keyPendxDP <= 1'b1;
                keyLatxDP  <= KeyWordxDI;
            end

            // The S-box never stalls, so the delay line shifts on bubbles too.
            vldPipexDP[0] <= issuexS;
            tagPipexDP[0] <= jobKeyxDP;
            for (int i = 1; i < SBOX_LATENCY; i++) begin
                vldPipexDP[i] <= vldPipexDP[i-1];
                tagPipexDP[i] <= tagPipexDP[i-1];
            end

            if (capturexS) begin
                workxDP   <= workNextxD;
                capCntxDP <= capCntxDP + 5'd1;
            end
            if (lastCapxS) begin
                if (capTagxS) begin
                    for (int s = 0; s < SHARES; s++) keyResxDP[s] <= workNextxD[s][3:0];
                end else begin
                    stateResxDP <= workNextxD;
                end
            end

            case (fsmxDP)
                IDLE: begin
                    if (keyPendxDP || statePendxDP) begin
                        jobKeyxDP <= keyPendxDP;
                        numxDP    <= keyPendxDP ? 5'd4 : 5'd16;
                        idxxDP    <= '0;
                        capCntxDP <= '0;
                        fsmxDP    <= ISSUE;
                        if (keyPendxDP) keyPendxDP <= 1'b0;
                        else            statePendxDP <= 1'b0;
                    end
                end
                ISSUE: begin
                    if (RndValidxSI) begin
                        idxxDP <= idxxDP + 5'd1;
                        if (idxxDP == numxDP - 5'd1) fsmxDP <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (lastCapxS) begin
                        fsmxDP       <= DONE;
                        stateDonexDP <= !capTagxS;
                        keyDonexDP   <= capTagxS;
                    end
                end
                default: fsmxDP <= IDLE;
            endcase
        end
    end

endmodule
